bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have parameter SATURATE, default 0, meaning 0 = wrap at terminal count and 1 = hold at terminal count.
REQ-003 The block SHALL have port Clock, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port Resetn, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port Clear, input, 1 bit, a synchronous active-high zero of all digits.
REQ-006 The block SHALL have port ENABLE, input, 1 bit, the count enable.
REQ-007 The block SHALL have port UP, input, 1 bit, where 1 = increment and 0 = decrement.
REQ-008 The block SHALL have port LOAD, input, 1 bit, the synchronous parallel-load strobe.
REQ-009 The block SHALL have port LOAD_VAL, input, 4*DIGITS bits, the load value; digit k occupies bits [4k+3:4k] and digit 0 is least significant.
REQ-010 The block SHALL have port BCD, output, 4*DIGITS bits, the registered count with the same digit packing as LOAD_VAL.
REQ-011 The block SHALL have port TC, output, 1 bit, the combinational terminal-count / cascade carry.
REQ-012 The block SHALL have port LOAD_ERR, output, 1 bit, a registered one-cycle pulse flagging a rejected load.

Function
REQ-013 Input priority SHALL be Resetn low, then Clear, then LOAD, then ENABLE, then hold.
REQ-014 LOAD with every LOAD_VAL digit <= 9 SHALL write LOAD_VAL into BCD at the next edge, ignoring ENABLE and UP.
REQ-015 LOAD with any LOAD_VAL digit > 9 SHALL leave BCD unchanged and set LOAD_ERR high for exactly the following cycle.
REQ-016 LOAD_ERR SHALL be low in every cycle except the one after a rejected load.
REQ-017 With ENABLE=1 and UP=1, digit 0 SHALL increment each cycle; a digit at 9 SHALL go to 0 and carry into the next digit, rippling through all digits in the same cycle.
REQ-018 With ENABLE=1 and UP=0, digit 0 SHALL decrement each cycle; a digit at 0 SHALL go to 9 and borrow from the next digit, rippling in the same cycle.
REQ-019 Terminal SHALL mean all digits equal 9 when UP=1, and all digits equal 0 when UP=0.
REQ-020 TC SHALL equal ENABLE AND (BCD at terminal for the current UP) AND NOT LOAD AND NOT Clear AND Resetn.
REQ-021 With SATURATE=0 at terminal, BCD SHALL wrap to all-0 when counting up and to all-9 when counting down.
REQ-022 With SATURATE=1 at terminal, BCD SHALL hold its value; TC SHALL still assert.
REQ-023 Changing UP between cycles SHALL take effect on the next edge with no dead cycle.
REQ-024 Count latency SHALL be one clock from ENABLE to the BCD update.
REQ-025 BCD digits SHALL never hold a value > 9, provided every loaded value is valid.

Reset
REQ-026 Resetn=0 at a rising edge SHALL set BCD to all-0 and LOAD_ERR to 0, overriding all other inputs.
REQ-027 Reset SHALL have no asynchronous effect; outputs SHALL change only at a clock edge.
REQ-028 Reset asserted mid-count or in the cycle after a rejected load SHALL clear the count and the LOAD_ERR pulse at that edge.
REQ-029 Clear SHALL behave as reset for BCD only and SHALL not suppress a LOAD_ERR pulse already registered.

Structure
REQ-030 The shared package bcd_pkg SHALL hold BCD_MAX = 4'd9, BCD_MIN = 4'd0 and the digit width constant BCD_W = 4.
REQ-031 One sub-module, bcd_digit, SHALL implement one digit register with inputs en, up, load, ld_val and clr, and output cin_out (carry/borrow out, meaning at 9 when up or at 0 when down, and en is set).
REQ-032 The top level SHALL instantiate DIGITS copies of bcd_digit in a generate loop, chaining each cin_out to the next digit's en, and SHALL hold the load check, saturation gating and LOAD_ERR register.

Verification (DIGITS=4)
REQ-033 The bench SHALL cover: reset, then ENABLE=1, UP=1 for 10000 cycles -> BCD counts 0000..9999 and wraps to 0000; TC is high only in the 9999 cycle.
REQ-034 The bench SHALL cover: LOAD_VAL=0x0100, then UP=0 for 1 cycle -> BCD=0099; continue 99 cycles -> 0000 with TC high; next cycle -> 9999.
REQ-035 The bench SHALL cover: SATURATE=1, load 9998, then count up 3 cycles -> 9999, 9999, 9999, with TC high for the last two cycles.
REQ-036 The bench SHALL cover: LOAD_VAL=0x12A4 -> BCD unchanged and LOAD_ERR=1 for exactly one cycle; a valid LOAD the next cycle is accepted.
REQ-037 The bench SHALL cover: LOAD, Clear and ENABLE asserted together at BCD=0555 -> BCD=0000; then LOAD with ENABLE -> BCD=LOAD_VAL with no increment.
REQ-038 The bench SHALL cover: Resetn=0 during counting at 4321 -> BCD=0000 at that edge; holding Resetn=0 keeps BCD=0000 regardless of ENABLE and LOAD.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
// Digit width, legal digit bounds and a per-digit validity check.
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic digit_ok(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: clear, parallel load, or increment/decrement with
// carry/borrow out to the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t ld_val,
    input  logic       en,
    input  logic       up,
    output bcd_digit_t q,
    output logic       cin_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = BCD_MIN;
        end else if (load) begin
            digit_d = ld_val;
        end else if (en) begin
            if (up) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry/borrow only when this digit is actually being stepped.
    assign cin_out = en & (up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
    assign q       = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, load validation,
// optional saturation at terminal count and a cascade terminal-count output.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      Clear,
    input  logic                      ENABLE,
    input  logic                      UP,
    input  logic                      LOAD,
    input  logic [BCD_W*DIGITS-1:0]   LOAD_VAL,
    output logic [BCD_W*DIGITS-1:0]   BCD,
    output logic                      TC,
    output logic                      LOAD_ERR
);

    logic [DIGITS:0]             chain;
    logic                        load_valid;
    logic                        load_ok;
    logic                        sat_hold;
    logic                        dig_load;
    logic [BCD_W*DIGITS-1:0]     dig_val;
    logic                        load_err_q;
    logic                        load_err_d;

    always_comb begin
        load_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!digit_ok(LOAD_VAL[k*BCD_W +: BCD_W])) begin
                load_valid = 1'b0;
            end
        end
    end

    // The ripple chain doubles as terminal detect: the last carry is high
    // exactly when a count step is requested and every digit is at terminal.
    assign chain[0] = ENABLE & ~LOAD & ~Clear;
    assign TC       = chain[DIGITS] & Resetn;

    // Saturation holds the count by reloading the current value.
    assign load_ok  = LOAD & ~Clear & load_valid;
    assign sat_hold = SATURATE & chain[DIGITS];
    assign dig_load = load_ok | sat_hold;
    assign dig_val  = load_ok ? LOAD_VAL : BCD;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk_sys (Clock),
            .rst_b   (Resetn),
            .clr     (Clear),
            .load    (dig_load),
            .ld_val  (dig_val[k*BCD_W +: BCD_W]),
            .en      (chain[k]),
            .up      (UP),
            .q       (BCD[k*BCD_W +: BCD_W]),
            .cin_out (chain[k+1])
        );
    end

    assign load_err_d = LOAD & ~Clear & ~load_valid;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: wrapping and saturating 4-digit counters driven in
// parallel, checked against an integer reference model and fixed vectors.
module tb_bcd_updown_counter;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Clear = 1'b0;
    logic        ENABLE = 1'b0;
    logic        UP = 1'b1;
    logic        LOAD = 1'b0;
    logic [15:0] LOAD_VAL = 16'h0000;
    logic [15:0] bcd0, bcd1;
    logic        tc0, tc1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    int m_val [2];
    bit m_err [2];
    bit tc_seen [2];

    typedef struct {
        bit          rstn;
        bit          clr;
        bit          ld;
        bit          en;
        bit          up;
        logic [15:0] val;
        logic [15:0] exp_bcd;
        bit          exp_err;
        bit          exp_tc;
    } vec_t;

    vec_t tbl [16];

    always #5 Clock = ~Clock;

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut (
        .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .ENABLE(ENABLE), .UP(UP),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .BCD(bcd0), .TC(tc0), .LOAD_ERR(err0)
    );

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
        .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .ENABLE(ENABLE), .UP(UP),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .BCD(bcd1), .TC(tc1), .LOAD_ERR(err1)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p;
        r = '0;
        p = v;
        for (int k = 0; k < 4; k++) begin
            r[k*4 +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_is_valid(input logic [15:0] b);
        for (int k = 0; k < 4; k++) begin
            if (b[k*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int r;
        int p;
        r = 0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r = r + int'(b[k*4 +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit model_tc(input int i);
        bit term;
        term = UP ? (m_val[i] == 9999) : (m_val[i] == 0);
        return ENABLE && term && !LOAD && !Clear && Resetn;
    endfunction

    function automatic void model_step(input int i, input bit sat);
        if (!Resetn) begin
            m_val[i] = 0;
            m_err[i] = 1'b0;
            return;
        end
        m_err[i] = LOAD && !Clear && !bcd_is_valid(LOAD_VAL);
        if (Clear) begin
            m_val[i] = 0;
        end else if (LOAD) begin
            if (bcd_is_valid(LOAD_VAL)) m_val[i] = from_bcd(LOAD_VAL);
        end else if (ENABLE) begin
            if (UP) begin
                if (m_val[i] == 9999) m_val[i] = sat ? 9999 : 0;
                else m_val[i] = m_val[i] + 1;
            end else begin
                if (m_val[i] == 0) m_val[i] = sat ? 0 : 9999;
                else m_val[i] = m_val[i] - 1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs must already be set; checks TC before the edge, state after it.
    task automatic tick();
        #1;
        tc_seen[0] = tc0;
        tc_seen[1] = tc1;
        check("tc_wrap", {31'd0, tc0}, {31'd0, model_tc(0)});
        check("tc_sat",  {31'd0, tc1}, {31'd0, model_tc(1)});
        @(posedge Clock);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        check("bcd_wrap", {16'd0, bcd0}, {16'd0, to_bcd(m_val[0])});
        check("bcd_sat",  {16'd0, bcd1}, {16'd0, to_bcd(m_val[1])});
        check("err_wrap", {31'd0, err0}, {31'd0, m_err[0]});
        check("err_sat",  {31'd0, err1}, {31'd0, m_err[1]});
    endtask

    task automatic drive(input bit rstn, input bit clr, input bit ld, input bit en,
                         input bit up, input logic [15:0] val);
        Resetn   = rstn;
        Clear    = clr;
        LOAD     = ld;
        ENABLE   = en;
        UP       = up;
        LOAD_VAL = val;
    endtask

    initial begin
        int tc_hits;
        m_val[0] = 0; m_val[1] = 0;
        m_err[0] = 0; m_err[1] = 0;

        //              rstn clr ld en up  val       bcd       err tc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0555, 16'h0555, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0777, 16'h0777, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h12A4, 16'h0777, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042, 16'h0042, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0041, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9F99, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0};

        @(posedge Clock);
        #1;
        for (int v = 0; v < 16; v++) begin
            drive(tbl[v].rstn, tbl[v].clr, tbl[v].ld, tbl[v].en, tbl[v].up, tbl[v].val);
            tick();
            check($sformatf("vec%0d_bcd", v), {16'd0, bcd0}, {16'd0, tbl[v].exp_bcd});
            check($sformatf("vec%0d_err", v), {31'd0, err0}, {31'd0, tbl[v].exp_err});
            check($sformatf("vec%0d_tc", v), {31'd0, tc_seen[0]}, {31'd0, tbl[v].exp_tc});
        end

        // Full up-count sweep with wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        tc_hits = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (tc_seen[0]) begin
                tc_hits++;
                check("sweep_tc_pos", i, 9999);
            end
        end
        check("sweep_tc_hits", tc_hits, 1);
        check("sweep_wrap", {16'd0, bcd0}, 32'h0000);

        // Down-count from 0100 through zero.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        check("down_0099", {16'd0, bcd0}, 32'h0099);
        repeat (99) tick();
        check("down_0000", {16'd0, bcd0}, 32'h0000);
        tick();
        check("down_tc", {31'd0, tc_seen[0]}, 32'd1);
        check("down_wrap", {16'd0, bcd0}, 32'h9999);

        // Saturation at 9999.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("sat_bcd%0d", j), {16'd0, bcd1}, 32'h9999);
            check($sformatf("sat_tc%0d", j), {31'd0, tc_seen[1]}, (j > 0) ? 32'd1 : 32'd0);
        end

        // Reset during counting, then held low.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h4321);
        tick();
        check("pre_rst_4321", {16'd0, bcd0}, 32'h4321);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
        tick();
        check("rst_mid", {16'd0, bcd0}, 32'h0000);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0777);
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("rst_hold%0d", j), {16'd0, bcd0}, 32'h0000);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            int pick;
            for (int k = 0; k < 4; k++) begin
                v[k*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                            : 4'($urandom_range(0, 9));
            end
            pick = $urandom_range(0, 3);
            if (pick == 0) v = 16'h9997;
            else if (pick == 1) v = 16'h0002;
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), v);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
